// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the convolution datapath blocks.
//   - ofmap_out_h / ofmap_out_w : output-map dimensions from image, kernel and
//                                 stride (constant functions, usable in
//                                 parameter declarations)
//   - ofmap_state_t / ST_*      : ofmap_collector FSM state type and encodings
//   - sat_signed                : clamps a wide signed value into the range of
//                                 a signed integer of a given width
// Ports: none (package).
// -----------------------------------------------------------------------------
package npu_pkg;

  // Number of window positions along one axis.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int ofmap_out_h(input int img_h, input int k_h, input int stride_h);
    return out_dim(img_h, k_h, stride_h);
  endfunction

  function automatic int ofmap_out_w(input int img_w, input int k_w, input int stride_w);
    return out_dim(img_w, k_w, stride_w);
  endfunction

  // Collector FSM state. Plain constants keep the encoding visible in
  // waveforms and stable across tools.
  typedef logic [1:0] ofmap_state_t;
  localparam ofmap_state_t ST_IDLE    = 2'd0;
  localparam ofmap_state_t ST_COLLECT = 2'd1;
  localparam ofmap_state_t ST_DONE    = 2'd2;

  // Clamp value to [-2^(width-1), 2^(width-1)-1]. width must be 1..63.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end
    if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/result_quantizer.sv
// -----------------------------------------------------------------------------
// result_quantizer
// Purely combinational conversion of one accumulated window result into an
// output-map element: arithmetic right shift by SHIFT, optional ReLU, then
// signed saturation to DATA_WIDTH bits.
// Build option: define OFMAP_RELU_EN to clamp negative results to 0 before
// saturation (output range becomes [0, 2^(DATA_WIDTH-1)-1]).
// Ports:
//   in_data  in  ACC_WIDTH   signed accumulated result
//   out_data out DATA_WIDTH  signed, scaled and saturated element
// -----------------------------------------------------------------------------
module result_quantizer
  import npu_pkg::*;
#(
  parameter int ACC_WIDTH  = 20,
  parameter int DATA_WIDTH = 8,
  parameter int SHIFT      = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  in_data,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [63:0]          wide;
  logic signed [63:0]          clamped;

  // Both operands signed, so >>> replicates the sign bit (floor division).
  assign shifted = in_data >>> SHIFT;

  always_comb begin
    // NOTE: every variable gets its default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    wide = 64'(shifted);
`ifdef OFMAP_RELU_EN
    if (wide < 0) begin
      wide = '0;
    end
`endif
    clamped = sat_signed(wide, DATA_WIDTH);
  end

  // clamped already lies within DATA_WIDTH signed range; drop the upper bits.
  assign out_data = DATA_WIDTH'(clamped);

endmodule

// File: rtl/ofmap_collector.sv
// -----------------------------------------------------------------------------
// ofmap_collector
// Collects one result per kernel window, in raster order, converts each one
// through result_quantizer and stores it into a flattened output feature map.
// Raises done/ofmap_valid when the last window result has been written.
// Build option: OFMAP_RELU_EN (see result_quantizer) enables ReLU.
// Ports:
//   clk          in   1                      rising-edge clock
//   rst          in   1                      asynchronous, active-high reset
//   start        in   1                      begin a new map (IDLE/DONE only)
//   in_valid     in   1                      in_data holds a window result
//   in_data      in   ACC_WIDTH              signed window result
//   in_ready     out  1                      result accepted this cycle
//   ofmap_flat   out  DATA_WIDTH*OUT_H*OUT_W element (r,c) at
//                                            [(r*OUT_W+c)*DATA_WIDTH +: DATA_WIDTH]
//   ofmap_valid  out  1                      map complete and stable
//   busy         out  1                      collection in progress
//   done         out  1                      one-cycle pulse after last write
// -----------------------------------------------------------------------------
module ofmap_collector
  import npu_pkg::*;
#(
  parameter  int ACC_WIDTH  = 20,
  parameter  int DATA_WIDTH = 8,
  parameter  int IMG_H      = 4,
  parameter  int IMG_W      = 4,
  parameter  int K_H        = 2,
  parameter  int K_W        = 2,
  parameter  int STRIDE_H   = 1,
  parameter  int STRIDE_W   = 1,
  parameter  int SHIFT      = 0,
  localparam int OUT_H      = ofmap_out_h(IMG_H, K_H, STRIDE_H),
  localparam int OUT_W      = ofmap_out_w(IMG_W, K_W, STRIDE_W)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                in_valid,
  input  logic signed [ACC_WIDTH-1:0]         in_data,
  output logic                                in_ready,
  output logic [DATA_WIDTH*OUT_H*OUT_W-1:0]   ofmap_flat,
  output logic                                ofmap_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int N_ELEM = OUT_H * OUT_W;
  localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

  ofmap_state_t                  state;
  logic [ROW_W-1:0]              row;
  logic [COL_W-1:0]              col;
  logic signed [DATA_WIDTH-1:0]  q_data;
  logic                          accept;
  logic                          last_elem;
  int                            elem_idx;

  result_quantizer #(
    .ACC_WIDTH (ACC_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .SHIFT     (SHIFT)
  ) u_quant (
    .in_data (in_data),
    .out_data(q_data)
  );

  // in_ready is high only in COLLECT, so this also drops in_valid elsewhere.
  assign accept    = in_valid && in_ready;
  assign last_elem = (row == ROW_LAST) && (col == COL_LAST);

  always_comb begin
    elem_idx = int'(row) * OUT_W + int'(col);
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ofmap_valid <= 1'b0;
      // NOTE: the map is a flop bank driving an output port, not a RAM; its
      // reset value is observable, so it is cleared along with the control.
      ofmap_flat  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_COLLECT;
            row         <= '0;
            col         <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b1;
            ofmap_valid <= 1'b0;
            ofmap_flat  <= '0;
          end
        end
        ST_COLLECT: begin
          // start is deliberately not looked at here.
          if (accept) begin
            for (int k = 0; k < N_ELEM; k++) begin
              if (elem_idx == k) begin
                ofmap_flat[k*DATA_WIDTH +: DATA_WIDTH] <= q_data;
              end
            end
            if (last_elem) begin
              state       <= ST_DONE;
              row         <= '0;
              col         <= '0;
              in_ready    <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              ofmap_valid <= 1'b1;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_collector.sv
// -----------------------------------------------------------------------------
// tb_ofmap_collector
// Drives two collectors from the same stimulus: dut_a with SHIFT=0 and dut_b
// with SHIFT=2. Expected maps come from an integer reference model (floor
// division by 2^SHIFT, optional ReLU, clamp). Honors OFMAP_RELU_EN.
// -----------------------------------------------------------------------------
module tb_ofmap_collector;

  localparam int N  = 9;
  localparam int DW = 8;
  localparam int FW = DW * N;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic signed [19:0] in_data;

  logic          in_ready_a, ofmap_valid_a, busy_a, done_a;
  logic [FW-1:0] flat_a;
  logic          in_ready_b, ofmap_valid_b, busy_b, done_b;
  logic [FW-1:0] flat_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ofmap_collector dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .ofmap_flat(flat_a), .ofmap_valid(ofmap_valid_a),
    .busy(busy_a), .done(done_a)
  );

  ofmap_collector #(.SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .ofmap_flat(flat_b), .ofmap_valid(ofmap_valid_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference conversion: floor(x / 2^sh), optional ReLU, clamp to int8.
  function automatic int model_q(input int x, input int sh);
    int d;
    int s;
    d = 1 << sh;
    s = (x >= 0) ? (x / d) : -((-x + d - 1) / d);
`ifdef OFMAP_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  function automatic logic [FW-1:0] model_map(input int vals[N], input int sh);
    logic [FW-1:0] m;
    m = '0;
    for (int k = 0; k < N; k++) m[k*DW +: DW] = DW'(model_q(vals[k], sh));
    return m;
  endfunction

  task automatic check_cleared(input string tag);
    check({tag, "/rdy_a"},  in_ready_a, 0);
    check({tag, "/busy_a"}, busy_a, 0);
    check({tag, "/done_a"}, done_a, 0);
    check({tag, "/val_a"},  ofmap_valid_a, 0);
    check({tag, "/map_a"},  flat_a, 0);
    check({tag, "/rdy_b"},  in_ready_b, 0);
    check({tag, "/map_b"},  flat_b, 0);
    check({tag, "/val_b"},  ofmap_valid_b, 0);
  endtask

  // Start a map, feed N results (optionally gapped), optionally pulse start
  // together with accept number poke_at, then check completion behaviour.
  task automatic run_map(input string tag, input int vals[N], input bit gapped,
                         input int poke_at);
    int i, cyc, da, db;
    logic [FW-1:0] exp_a, exp_b;
    exp_a = model_map(vals, 0);
    exp_b = model_map(vals, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "/start_rdy"},  in_ready_a, 1);
    check({tag, "/start_busy"}, busy_b, 1);
    check({tag, "/start_val"},  ofmap_valid_a, 0);
    check({tag, "/start_map"},  flat_a, 0);
    i = 0; cyc = 0; da = 0; db = 0;
    while (i < N && cyc < 4 * N + 10) begin
      in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
      in_data  = 20'(vals[i]);
      start    = in_valid && (i == poke_at);
      tick();
      start = 1'b0;
      if (in_valid) i++;
      cyc++;
      if (done_a) da++;
      if (done_b) db++;
      if (i == 1 && in_valid) check({tag, "/first_elem"}, flat_a[DW-1:0], exp_a[DW-1:0]);
    end
    in_valid = 1'b0;
    check({tag, "/accepts"}, i, N);
    check({tag, "/done_a"},  done_a, 1);
    check({tag, "/done_b"},  done_b, 1);
    check({tag, "/val_a"},   ofmap_valid_a, 1);
    check({tag, "/rdy_a"},   in_ready_a, 0);
    check({tag, "/busy_a"},  busy_a, 0);
    check({tag, "/map_a"},   flat_a, exp_a);
    check({tag, "/map_b"},   flat_b, exp_b);
    tick();
    check({tag, "/done_low"}, done_a, 0);
    check({tag, "/val_hold"}, ofmap_valid_a, 1);
    check({tag, "/rdy_hold"}, in_ready_a, 0);
    check({tag, "/map_hold"}, flat_a, exp_a);
    check({tag, "/pulses_a"}, da, 1);
    check({tag, "/pulses_b"}, db, 1);
  endtask

  function automatic int rand_val();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 400)) - 200;
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  initial begin
    int full_vals[N];
    int edge_vals[N];
    int rnd_vals[N];
    full_vals = '{14, 18, 22, 30, 34, 38, 46, 50, 54};
    edge_vals = '{300, -300, 14, -5, 0, -1, 127, 128, -129};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #12;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // in_valid in IDLE is dropped.
    in_valid = 1'b1; in_data = 20'sd99;
    tick();
    tick();
    in_valid = 1'b0;
    check_cleared("idle_drop");

    run_map("full", full_vals, 1'b0, -1);

    // in_valid in DONE is dropped; map holds.
    in_valid = 1'b1; in_data = 20'sd5;
    tick();
    in_valid = 1'b0;
    check("done_drop/map", flat_a, model_map(full_vals, 0));
    check("done_drop/val", ofmap_valid_a, 1);

    // Restart from DONE with saturation/shift corner values; start mid-map.
    run_map("satshift", edge_vals, 1'b0, 4);

    // Gapped input, start coinciding with the final accept.
    run_map("gapped", full_vals, 1'b1, N - 1);

    // Reset mid-map: outputs clear without a clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 20'(full_vals[k]);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check_cleared("midreset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) rnd_vals[k] = rand_val();
      run_map($sformatf("rand%0d", r), rnd_vals, r[0], -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
